// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants (640x480@60 defaults) and the total-period helper
// used by the sync generator, board wrappers and benches.
package vga_timing_pkg;

  localparam int DEF_CLK_MHZ       = 50;
  localparam int DEF_PIXEL_MHZ     = 25;
  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_H_FRONT       = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_BACK        = 48;
  localparam int DEF_V_FRONT       = 10;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_BACK        = 33;

  // Full period of one axis: active region plus both porches and the sync pulse.
  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/pixel_strobe_gen.sv
// Divides the system clock into a one-clk pixel enable, high once every R clocks.
module pixel_strobe_gen #(
  parameter int R = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pixel_strobe
);

  // Keep at least one bit so R=1 still elaborates; the count then stays at 0.
  localparam int DW = (R > 1) ? $clog2(R) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(R - 1);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Decoded from the registered count, so R=1 gives a constant 1 from reset.
  assign pixel_strobe = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel divider, h/v position counters and registered
// sync / active-area / coordinate decodes for the game and graphics stage.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int clk_mhz       = DEF_CLK_MHZ,
  parameter int pixel_mhz     = DEF_PIXEL_MHZ,
  parameter int screen_width  = DEF_SCREEN_WIDTH,
  parameter int screen_height = DEF_SCREEN_HEIGHT,
  parameter int h_front       = DEF_H_FRONT,
  parameter int h_sync        = DEF_H_SYNC,
  parameter int h_back        = DEF_H_BACK,
  parameter int v_front       = DEF_V_FRONT,
  parameter int v_sync        = DEF_V_SYNC,
  parameter int v_back        = DEF_V_BACK,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pixel_strobe,
  output logic           hsync,
  output logic           vsync,
  output logic           display_on,
  output logic [w_x-1:0] x,
  output logic [w_y-1:0] y,
  output logic           frame_start
);

  localparam int R       = clk_mhz / pixel_mhz;
  localparam int H_TOTAL = timing_total(screen_width, h_front, h_sync, h_back);
  localparam int V_TOTAL = timing_total(screen_height, v_front, v_sync, v_back);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(screen_width);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(screen_width + h_front);
  localparam logic [HW-1:0] H_SYNC_END = HW'(screen_width + h_front + h_sync);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(screen_height);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(screen_height + v_front);
  localparam logic [VW-1:0] V_SYNC_END = VW'(screen_height + v_front + v_sync);

  if (clk_mhz % pixel_mhz != 0) begin : g_ratio_check
    $error("vga_sync_gen: clk_mhz (%0d) is not a multiple of pixel_mhz (%0d)",
           clk_mhz, pixel_mhz);
  end

  pixel_strobe_gen #(
    .R(R)
  ) u_strobe (
    .clk         (clk),
    .rst         (rst),
    .pixel_strobe(pixel_strobe)
  );

  logic [HW-1:0]  h, h_next;
  logic [VW-1:0]  v, v_next;
  logic           h_wrap, v_wrap;
  logic           display_on_next, hsync_next, vsync_next;
  logic [w_x-1:0] x_next;
  logic [w_y-1:0] y_next;

  // Decodes look at the next position so they land on the same edge as the counters.
  always_comb begin
    h_wrap          = (h == H_LAST);
    v_wrap          = (v == V_LAST);
    h_next          = h_wrap ? '0 : h + 1'b1;
    v_next          = v;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v + 1'b1;
    end
    display_on_next = (h_next < H_ACT) && (v_next < V_ACT);
    hsync_next      = !((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END));
    vsync_next      = !((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END));
    x_next          = display_on_next ? h_next[w_x-1:0] : '0;
    y_next          = display_on_next ? v_next[w_y-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pixel_strobe) begin
        h           <= h_next;
        v           <= v_next;
        hsync       <= hsync_next;
        vsync       <= vsync_next;
        display_on  <= display_on_next;
        x           <= x_next;
        y           <= y_next;
        frame_start <= h_wrap && v_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default, small-raster and R=1 instances compared every
// clk against a closed-form model of position versus clocks since reset.
module tb_vga_sync_gen;

  typedef struct packed {
    logic        strobe;
    logic        hsync;
    logic        vsync;
    logic        disp;
    logic        fs;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  // small raster, R=2: 25 x 15 pixels per frame, 750 clks
  localparam int S_W = 16, S_H = 8, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int S_VF = 2, S_VS = 2, S_VB = 3, S_R = 2;
  localparam int S_HT = S_W + S_HF + S_HS + S_HB;
  localparam int S_VT = S_H + S_VF + S_VS + S_VB;
  // tiny raster, R=1: 12 x 7 pixels per frame
  localparam int O_W = 8, O_H = 4, O_HF = 1, O_HS = 2, O_HB = 1;
  localparam int O_VF = 1, O_VS = 1, O_VB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       d_strobe, d_hsync, d_vsync, d_disp, d_fs;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       s_strobe, s_hsync, s_vsync, s_disp, s_fs;
  logic [3:0] s_x;
  logic [2:0] s_y;
  logic       o_strobe, o_hsync, o_vsync, o_disp, o_fs;
  logic [2:0] o_x;
  logic [1:0] o_y;

  vga_sync_gen u_dflt (
    .clk(clk), .rst(rst), .pixel_strobe(d_strobe), .hsync(d_hsync), .vsync(d_vsync),
    .display_on(d_disp), .x(d_x), .y(d_y), .frame_start(d_fs)
  );

  vga_sync_gen #(
    .clk_mhz(50), .pixel_mhz(25), .screen_width(S_W), .screen_height(S_H),
    .h_front(S_HF), .h_sync(S_HS), .h_back(S_HB),
    .v_front(S_VF), .v_sync(S_VS), .v_back(S_VB)
  ) u_small (
    .clk(clk), .rst(rst), .pixel_strobe(s_strobe), .hsync(s_hsync), .vsync(s_vsync),
    .display_on(s_disp), .x(s_x), .y(s_y), .frame_start(s_fs)
  );

  vga_sync_gen #(
    .clk_mhz(25), .pixel_mhz(25), .screen_width(O_W), .screen_height(O_H),
    .h_front(O_HF), .h_sync(O_HS), .h_back(O_HB),
    .v_front(O_VF), .v_sync(O_VS), .v_back(O_VB)
  ) u_one (
    .clk(clk), .rst(rst), .pixel_strobe(o_strobe), .hsync(o_hsync), .vsync(o_vsync),
    .display_on(o_disp), .x(o_x), .y(o_y), .frame_start(o_fs)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after k clk edges since the last reset edge: k/r pixels
  // have elapsed, position is that pixel index unrolled over the raster.
  function automatic exp_t model(input int k, input int r, input int sw, input int sh,
                                 input int hf, input int hs, input int hb,
                                 input int vf, input int vs, input int vb);
    exp_t e;
    int ht, vt, p, h, v;
    ht = sw + hf + hs + hb;
    vt = sh + vf + vs + vb;
    p  = k / r;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.strobe = ((k % r) == r - 1);
    if (p == 0) begin
      e.hsync = 1'b1;
      e.vsync = 1'b1;
      e.disp  = 1'b0;
      e.fs    = 1'b0;
      e.x     = '0;
      e.y     = '0;
    end else begin
      e.disp  = (h < sw) && (v < sh);
      e.hsync = !((h >= sw + hf) && (h < sw + hf + hs));
      e.vsync = !((v >= sh + vf) && (v < sh + vf + vs));
      e.x     = e.disp ? 16'(h) : 16'd0;
      e.y     = e.disp ? 16'(v) : 16'd0;
      e.fs    = ((k % r) == 0) && ((p % (ht * vt)) == 0);
    end
    return e;
  endfunction

  task automatic compare_outputs(input string who, input exp_t obs, input exp_t exp);
    check({who, ".pixel_strobe"}, 32'(obs.strobe), 32'(exp.strobe));
    check({who, ".hsync"},        32'(obs.hsync),  32'(exp.hsync));
    check({who, ".vsync"},        32'(obs.vsync),  32'(exp.vsync));
    check({who, ".display_on"},   32'(obs.disp),   32'(exp.disp));
    check({who, ".frame_start"},  32'(obs.fs),     32'(exp.fs));
    check({who, ".x"},            32'(obs.x),      32'(exp.x));
    check({who, ".y"},            32'(obs.y),      32'(exp.y));
  endtask

  // clk edges since the most recent reset edge
  int k     = 0;
  bit armed = 1'b0;
  always @(posedge clk) begin
    armed <= armed | rst;
    k     <= rst ? 0 : k + 1;
  end

  always @(negedge clk) begin
    exp_t obs;
    if (armed) begin
      obs = '{strobe: d_strobe, hsync: d_hsync, vsync: d_vsync, disp: d_disp,
              fs: d_fs, x: 16'(d_x), y: 16'(d_y)};
      compare_outputs("dflt", obs, model(k, 2, 640, 480, 16, 96, 48, 10, 2, 33));
      obs = '{strobe: s_strobe, hsync: s_hsync, vsync: s_vsync, disp: s_disp,
              fs: s_fs, x: 16'(s_x), y: 16'(s_y)};
      compare_outputs("small", obs, model(k, S_R, S_W, S_H, S_HF, S_HS, S_HB, S_VF, S_VS, S_VB));
      obs = '{strobe: o_strobe, hsync: o_hsync, vsync: o_vsync, disp: o_disp,
              fs: o_fs, x: 16'(o_x), y: 16'(o_y)};
      compare_outputs("r1", obs, model(k, 1, O_W, O_H, O_HF, O_HS, O_HB, O_VF, O_VS, O_VB));
    end
  end

  // Whole-period measurements: sync pulse widths, frame period, active strobes.
  int s_run = -1, d_run = -1, s_last_fs = -1, s_disp_cnt = -1;
  int s_runs_seen = 0, d_runs_seen = 0, s_frames_seen = 0;
  always @(negedge clk) begin
    if (armed) begin
      if (k == 0) begin
        s_run      = -1;
        d_run      = -1;
        s_last_fs  = -1;
        s_disp_cnt = -1;
      end else begin
        if (!s_hsync) begin
          if (s_run >= 0) s_run++;
        end else begin
          if (s_run > 0) begin
            check("small.hsync_low_clks", 32'(s_run), 32'(S_HS * S_R));
            s_runs_seen++;
          end
          s_run = 0;
        end
        if (!d_hsync) begin
          if (d_run >= 0) d_run++;
        end else begin
          if (d_run > 0) begin
            check("dflt.hsync_low_clks", 32'(d_run), 32'd192);
            d_runs_seen++;
          end
          d_run = 0;
        end
        if (s_fs) begin
          if (s_last_fs >= 0) begin
            check("small.frame_clks", 32'(k - s_last_fs), 32'(S_HT * S_VT * S_R));
            check("small.active_strobes", 32'(s_disp_cnt), 32'(S_W * S_H));
            s_frames_seen++;
          end
          s_last_fs  = k;
          s_disp_cnt = 0;
        end
        if (s_disp_cnt >= 0 && s_strobe && s_disp) s_disp_cnt++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    // long clean run: default line plus several small frames
    repeat (2000) @(negedge clk);
    // fresh start, then a one-clk reset while the small raster sits at (10,5)
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat ((5 * S_HT + 10) * S_R) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (1700) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(40, 900)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (1600) @(negedge clk);
    check("small.hsync_runs_seen", 32'(s_runs_seen > 3), 32'd1);
    check("dflt.hsync_runs_seen", 32'(d_runs_seen > 0), 32'd1);
    check("small.frames_seen", 32'(s_frames_seen > 1), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
